fetch_tick_queue: RTL

Paced fetch-request queue that consumes the periodic overflow tick of the mod-n rate counter. It buffers fetch addresses pushed by the upstream PC generator and releases at most one entry per tick to the downstream fetch port over a valid/ready handshake. It also drives the rate counter's enable so the counter runs only while work is pending.

---
 rtl/fetch_tick_queue_pkg.sv | 14 +
 rtl/ftq_storage.sv | 48 ++++
 rtl/fetch_tick_queue.sv | 90 +++++++++
 3 files changed

// File: rtl/fetch_tick_queue_pkg.sv
// Shared types and constants for the tick-paced fetch request queue.
package fetch_tick_queue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ARMED = 2'd2
  } ftq_state_e;

  localparam int MISS_W      = 8;
  localparam int FTQ_DATA_W  = 32;
  localparam int FTQ_DEPTH   = 4;

endpackage

// File: rtl/ftq_storage.sv
// Circular register-array FIFO storage: pointers and occupancy, no flow control.
module ftq_storage #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data array carries no reset; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_tick_queue.sv
// Fetch queue releasing at most one entry per rate-counter tick.
// Optional lost-tick counter enabled by FETCH_TICK_QUEUE_MISS_CNT_EN.
module fetch_tick_queue
  import fetch_tick_queue_pkg::*;
#(
  parameter int DATA_W = FTQ_DATA_W,
  parameter int DEPTH  = FTQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  output logic              cntr_enb,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic [MISS_W-1:0] tick_miss_cnt
);

  ftq_state_e state, state_nxt;
  logic push, pop, emptying;

  assign in_ready  = !full;
  assign out_valid = (state == ARMED);
  assign cntr_enb  = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign emptying  = pop && !push && (count == (PTR_W+1)'(1));

  ftq_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_storage (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A single credit: a tick arms the head, a pop spends it unless a tick lands with it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = WAIT;
      WAIT:    if (tick) state_nxt = ARMED;
      ARMED: begin
        if (pop) begin
          if (emptying)  state_nxt = IDLE;
          else if (tick) state_nxt = ARMED;
          else           state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FETCH_TICK_QUEUE_MISS_CNT_EN
  logic discard;
  logic [MISS_W-1:0] miss_cnt;

  assign discard = tick && ((state == IDLE) ||
                            ((state == ARMED) && (!pop || emptying)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           miss_cnt <= '0;
    else if (discard && !(&miss_cnt))  miss_cnt <= miss_cnt + 1'b1;
  end

  assign tick_miss_cnt = miss_cnt;
`else
  assign tick_miss_cnt = '0;
`endif

endmodule
